// File: rtl/booth_multiplier.sv
// Two-stage signed WIDTH x WIDTH radix-4 Booth multiplier: operand registers, then the partial-product sum registered.
// Optional valid handshake is enabled by defining BOOTH_MULT_VALID_EN.

package booth_multiplier_pkg;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_POS1 = 3'd1,
    BOOTH_POS2 = 3'd2,
    BOOTH_NEG1 = 3'd3,
    BOOTH_NEG2 = 3'd4
  } booth_digit_e;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_recode(input logic [2:0] triplet);
    booth_digit_e digit;
    case (triplet)
      3'b001, 3'b010: digit = BOOTH_POS1;
      3'b011:         digit = BOOTH_POS2;
      3'b100:         digit = BOOTH_NEG2;
      3'b101, 3'b110: digit = BOOTH_NEG1;
      default:        digit = BOOTH_ZERO;
    endcase
    return digit;
  endfunction

endpackage

module booth_multiplier
  import booth_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
`ifdef BOOTH_MULT_VALID_EN
  input  logic               in_valid,
  output logic               out_valid,
`endif
  output logic [2*WIDTH-1:0] clocked_out
);

  localparam int PW   = 2 * WIDTH;
  localparam int NDIG = WIDTH / 2;
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             load_s1, load_s2;

`ifdef BOOTH_MULT_VALID_EN
  logic valid1_q, valid2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      valid1_q <= in_valid;
      valid2_q <= valid1_q;
    end
  end

  assign load_s1   = in_valid;
  assign load_s2   = valid1_q;
  assign out_valid = valid2_q;
`else
  assign load_s1 = 1'b1;
  assign load_s2 = 1'b1;
`endif

  always_comb begin
    a_d = load_s1 ? in1 : a_q;
    b_d = load_s1 ? in2 : b_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  logic [WIDTH:0]   b_ext;
  logic [PW-1:0]    a_ext, a_ext_x2;
  booth_digit_e     digit [NDIG];
  logic [PW-1:0]    pp    [NDIG];
  logic [PW-1:0]    pp_sum;

  assign b_ext    = {b_q, 1'b0};
  assign a_ext    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign a_ext_x2 = a_ext << 1;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      logic [PW-1:0] term;
      digit[i] = booth_recode(b_ext[2*i +: 3]);
      case (digit[i])
        BOOTH_POS1: term = a_ext;
        BOOTH_POS2: term = a_ext_x2;
        BOOTH_NEG1: term = (~a_ext) + ONE;
        BOOTH_NEG2: term = (~a_ext_x2) + ONE;
        default:    term = '0;
      endcase
      pp[i] = term << (2 * i);
    end
  end

  // Wrap-around sum is exact: the true product always fits in PW bits.
  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < NDIG; i++) begin
      pp_sum = pp_sum + pp[i];
    end
    prod_d = load_s2 ? pp_sum : prod_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign clocked_out = prod_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corners, streaming, reset cases and a full operand sweep
// against an arithmetic reference model (valid gaps exercised when BOOTH_MULT_VALID_EN is defined).

module tb_booth_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  typedef struct {
    logic          v;
    logic [PW-1:0] p;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in1, in2;
  logic [PW-1:0] clocked_out;
`ifdef BOOTH_MULT_VALID_EN
  logic          in_valid;
  logic          out_valid;
`endif

  int            checks   = 0;
  int            failures = 0;
  exp_t          exp_q[$];
  logic [PW-1:0] last_out;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in1         (in1),
    .in2         (in2),
`ifdef BOOTH_MULT_VALID_EN
    .in_valid    (in_valid),
    .out_valid   (out_valid),
`endif
    .clocked_out (clocked_out)
  );

  always #5 clk = ~clk;

  // After reset the output register holds 0 and nothing valid is in flight.
  task automatic reset_model();
    exp_t seed;
    seed.v = 1'b0;
    seed.p = '0;
    exp_q.delete();
    exp_q.push_back(seed);
    last_out = '0;
  endtask

  function automatic logic rand_valid();
`ifdef BOOTH_MULT_VALID_EN
    return ($urandom_range(0, 3) != 0);
`else
    return 1'b1;
`endif
  endfunction

  // Drive one operand pair, advance one cycle, return the expected output now visible.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic v, output exp_t e);
    int   sa, sb, prod;
    exp_t n;
    sa   = $signed(a);
    sb   = $signed(b);
    prod = sa * sb;
    n.v  = v;
    n.p  = prod[PW-1:0];
    in1  = a;
    in2  = b;
`ifdef BOOTH_MULT_VALID_EN
    in_valid = v;
`endif
    exp_q.push_back(n);
    @(posedge clk);
    #1;
    in1 = W'($urandom);
    in2 = W'($urandom);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.v) last_out = e.p;
    e.p = last_out;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
`ifdef BOOTH_MULT_VALID_EN
    in_valid = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      in1 = W'($urandom);
      in2 = W'($urandom);
      @(negedge clk);
      checks++;
      if (clocked_out !== '0) begin
        failures++;
        $display("FAIL reset_hold[%0d] clocked_out=%h expected=0", i, clocked_out);
      end
`ifdef BOOTH_MULT_VALID_EN
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold_valid[%0d] out_valid=%b expected=0", i, out_valid);
      end
`endif
    end
    rst = 1'b0;
    reset_model();
    step(8'd5, 8'hFD, 1'b1, e);
    checks++;
    if (clocked_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_first clocked_out=%h expected=0000", clocked_out);
    end
    step(8'd0, 8'd0, 1'b1, e);
    checks++;
    if (clocked_out !== 16'hFFF1 || clocked_out !== e.p) begin
      failures++;
      $display("FAIL reset_after_release clocked_out=%h expected=fff1", clocked_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (clocked_out !== '0) begin
      failures++;
      $display("FAIL reset_async clocked_out=%h expected=0", clocked_out);
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_basic();
    exp_t e;
    step(8'hF8, 8'd10, 1'b1, e);
    step(8'd0, 8'd0, 1'b1, e);
    checks++;
    if (clocked_out !== 16'hFFB0 || clocked_out !== e.p) begin
      failures++;
      $display("FAIL basic_neg8x10 clocked_out=%h expected=ffb0", clocked_out);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]  ta [4] = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    logic [W-1:0]  tb [4] = '{8'h80, 8'h80, 8'hFF, 8'hB3};
    logic [PW-1:0] tp [4] = '{16'h4000, 16'hC080, 16'h0001, 16'h0000};
    exp_t e;
    for (int k = 0; k <= 4; k++) begin
      step((k < 4) ? ta[k] : 8'd0, (k < 4) ? tb[k] : 8'd0, 1'b1, e);
      if (k >= 1) begin
        checks++;
        if (clocked_out !== tp[k-1] || clocked_out !== e.p) begin
          failures++;
          $display("FAIL corner[%0d] clocked_out=%h expected=%h", k - 1, clocked_out, tp[k-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  ta [4] = '{8'd3, 8'hF9, 8'd100, 8'h80};
    logic [W-1:0]  tb [4] = '{8'd5, 8'd9, 8'h9C, 8'd1};
    logic [PW-1:0] tp [4] = '{16'h000F, 16'hFFC1, 16'hD8F0, 16'hFF80};
    exp_t e;
    for (int k = 0; k <= 4; k++) begin
      step((k < 4) ? ta[k] : 8'd0, (k < 4) ? tb[k] : 8'd0, 1'b1, e);
      if (k >= 1) begin
        checks++;
        if (clocked_out !== tp[k-1] || clocked_out !== e.p) begin
          failures++;
          $display("FAIL stream[%0d] clocked_out=%h expected=%h", k - 1, clocked_out, tp[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    step(8'd5, 8'd7, 1'b1, e);
    step(8'd9, 8'd9, 1'b1, e);
    checks++;
    if (clocked_out !== 16'd35) begin
      failures++;
      $display("FAIL midflight_pre clocked_out=%h expected=0023", clocked_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (clocked_out !== '0) begin
      failures++;
      $display("FAIL midflight_async clocked_out=%h expected=0", clocked_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (clocked_out !== '0) begin
      failures++;
      $display("FAIL midflight_held clocked_out=%h expected=0", clocked_out);
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    step(8'd2, 8'd3, 1'b1, e);
    checks++;
    if (clocked_out !== '0) begin
      failures++;
      $display("FAIL midflight_stale clocked_out=%h expected=0", clocked_out);
    end
    step(8'd0, 8'd0, 1'b1, e);
    checks++;
    if (clocked_out !== 16'd6) begin
      failures++;
      $display("FAIL midflight_first clocked_out=%h expected=0006", clocked_out);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int k = 0; k < 300; k++) begin
      step(W'($urandom), W'($urandom), rand_valid(), e);
      checks++;
      if (clocked_out !== e.p) begin
        failures++;
        $display("FAIL random[%0d] clocked_out=%h expected=%h", k, clocked_out, e.p);
      end
`ifdef BOOTH_MULT_VALID_EN
      checks++;
      if (out_valid !== e.v) begin
        failures++;
        $display("FAIL random_valid[%0d] out_valid=%b expected=%b", k, out_valid, e.v);
      end
`endif
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    logic [2*W-1:0] idx;
    for (int k = 0; k <= (1 << (2 * W)); k++) begin
      idx = k[2*W-1:0];
      if (k < (1 << (2 * W))) step(idx[2*W-1:W], idx[W-1:0], rand_valid(), e);
      else                    step(8'd0, 8'd0, 1'b1, e);
      checks++;
      if (clocked_out !== e.p) begin
        failures++;
        $display("FAIL sweep[%0d] clocked_out=%h expected=%h", k, clocked_out, e.p);
      end
`ifdef BOOTH_MULT_VALID_EN
      checks++;
      if (out_valid !== e.v) begin
        failures++;
        $display("FAIL sweep_valid[%0d] out_valid=%b expected=%b", k, out_valid, e.v);
      end
`endif
    end
  endtask

  initial begin
    in1 = '0;
    in2 = '0;
    rst = 1'b1;
`ifdef BOOTH_MULT_VALID_EN
    in_valid = 1'b0;
`endif
    reset_model();
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
